sample_packer: RTL

- Write-side producer for the sample FIFO in the fast clock domain.
- Samples the 16 PROBE inputs at a programmable rate and transposes each 16-sample group into one 16-bit word per enabled channel.
- Drives sample_data/sample_data_avail into the FIFO write port and detects FIFO overflow.
- Counterpart of the FX2-side FIFO reader: it supplies the data that the reader drains.

---
 rtl/sample_packer_if.sv | 25 ++
 rtl/sample_packer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sample_packer_if.sv
// rtl/sample_packer_if.sv - FIFO write-port bundle between sample_packer and the sample FIFO
//
// Signals:
//   sample_data       word presented to the FIFO din (packer -> FIFO)
//   sample_data_avail one-cycle write strobe per word (packer -> FIFO)
//   fifo_full         FIFO write-side full flag (FIFO -> packer)
// Modports: master = packer side, slave = FIFO side.

interface sample_packer_if;
    logic [15:0] sample_data;
    logic        sample_data_avail;
    logic        fifo_full;

    modport master (
        output sample_data,
        output sample_data_avail,
        input  fifo_full
    );

    modport slave (
        input  sample_data,
        input  sample_data_avail,
        output fifo_full
    );
endinterface

// File: rtl/sample_packer.sv
// rtl/sample_packer.sv - samples 16 probes, transposes 16-sample groups into per-channel FIFO words
//
// Ports:
//   clk          fast sample clock, also the FIFO write clock
//   rst_n        asynchronous active-low reset
//   enable       capture run request; a 0->1 edge starts a capture
//   divider      sample tick every divider+1 clocks (latched at start)
//   channel_mask bit i set = channel i emitted (latched at start)
//   probe        raw probe pins, registered before use
//   fifo         FIFO write port (sample_data, sample_data_avail, fifo_full)
//   overflow     sticky: a word was dropped because the FIFO was full
//   running      capture active

module sample_packer #(
    parameter int DIV_WIDTH = 8,
    parameter int NCH       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic [NCH-1:0]       channel_mask,
    input  logic [NCH-1:0]       probe,
    sample_packer_if.master      fifo,
    output logic                 overflow,
    output logic                 running
);
    localparam int GRP = 16;
    localparam int IW  = $clog2(NCH);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t               state;
    logic                 enable_q;
    logic [NCH-1:0]       probe_q;
    logic [NCH-1:0]       mask_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [3:0]           samp_cnt;
    logic [GRP-1:0]       sr      [NCH];
    logic [GRP-1:0]       sr_next [NCH];
    logic [GRP-1:0]       hold    [NCH];
    logic [NCH-1:0]       pend;
    logic [15:0]          data_q;
    logic                 word_valid;

    logic                 start;
    logic                 tick;
    logic                 arm;
    logic                 emit_busy;
    logic                 overrun;
    logic [NCH-1:0]       sel_mask;
    logic [IW-1:0]        sel_idx;
    logic [NCH-1:0]       sel_rest;
    logic [GRP-1:0]       sel_word;

    function automatic logic [IW-1:0] lowest_set(input logic [NCH-1:0] m);
        logic [IW-1:0] r;
        r = '0;
        // Descending scan so the lowest set bit is the last one written.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = IW'(i);
        end
        return r;
    endfunction

    assign start     = enable & ~enable_q;
    assign tick      = running & (div_cnt == '0);
    assign arm       = tick & (samp_cnt == 4'd15);
    assign emit_busy = (state == EMIT);
    assign overrun   = word_valid & fifo.fifo_full;

    // Shift registers as they will look after this tick; the group-complete
    // tick copies this straight into hold so the 16th sample is included.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sr_next[i]           = sr[i];
            sr_next[i][samp_cnt] = probe_q[i];
        end
    end

    // On arm the first word is taken from the freshly completed group so it
    // can appear the very next cycle; afterwards words come from hold.
    assign sel_mask = arm ? mask_q : pend;
    assign sel_idx  = lowest_set(sel_mask);
    assign sel_rest = sel_mask & ~(NCH'(1) << sel_idx);
    assign sel_word = arm ? sr_next[sel_idx] : hold[sel_idx];

    // The strobe is withheld in the same cycle the FIFO reports full or the
    // run request drops, so no word is written after either event.
    assign fifo.sample_data       = data_q;
    assign fifo.sample_data_avail = word_valid & ~fifo.fifo_full & enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            enable_q   <= 1'b0;
            probe_q    <= '0;
            mask_q     <= '0;
            div_q      <= '0;
            div_cnt    <= '0;
            samp_cnt   <= '0;
            pend       <= '0;
            data_q     <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
            running    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                sr[i]   <= '0;
                hold[i] <= '0;
            end
        end else begin
            enable_q <= enable;
            probe_q  <= probe;

            if (!enable) begin
                running    <= 1'b0;
                state      <= IDLE;
                word_valid <= 1'b0;
                pend       <= '0;
                samp_cnt   <= '0;
                div_cnt    <= '0;
            end else if (start) begin
                mask_q     <= channel_mask;
                div_q      <= divider;
                div_cnt    <= '0;
                samp_cnt   <= '0;
                overflow   <= 1'b0;
                running    <= 1'b1;
                state      <= IDLE;
                word_valid <= 1'b0;
                pend       <= '0;
            end else if (running && overrun) begin
                overflow   <= 1'b1;
                running    <= 1'b0;
                state      <= IDLE;
                word_valid <= 1'b0;
                pend       <= '0;
            end else if (running) begin
                div_cnt <= (div_cnt == div_q) ? '0 : div_cnt + 1'b1;

                if (tick) begin
                    for (int i = 0; i < NCH; i++) sr[i] <= sr_next[i];
                    samp_cnt <= samp_cnt + 4'd1;
                end

                if (arm) begin
                    for (int i = 0; i < NCH; i++) hold[i] <= sr_next[i];
                end

                if (arm || emit_busy) begin
                    if (sel_mask != '0) begin
                        data_q     <= sel_word;
                        word_valid <= 1'b1;
                        pend       <= sel_rest;
                        // Leave EMIT as the last word is loaded so a back-to-back
                        // arm (full mask, divider 0) finds the emitter idle.
                        state      <= (sel_rest != '0) ? EMIT : IDLE;
                    end else begin
                        word_valid <= 1'b0;
                        pend       <= '0;
                        state      <= IDLE;
                    end
                end else begin
                    word_valid <= 1'b0;
                end
            end else begin
                word_valid <= 1'b0;
            end
        end
    end
endmodule
